// File: rtl/bike_pos_pkg.sv
// Shared definitions for the bike-position button path: position indices,
// one-hot position codes and a small popcount helper.
package bike_pos_pkg;

    localparam int POS_DROPS = 0;
    localparam int POS_HOODS = 1;
    localparam int POS_TOPS  = 2;
    localparam int POS_BAR   = 3;
    localparam int POS_SEAT  = 4;
    localparam int N_POS     = 5;

    localparam logic [N_POS-1:0] ONEHOT_DROPS = 5'b00001;
    localparam logic [N_POS-1:0] ONEHOT_HOODS = 5'b00010;
    localparam logic [N_POS-1:0] ONEHOT_TOPS  = 5'b00100;
    localparam logic [N_POS-1:0] ONEHOT_BAR   = 5'b01000;
    localparam logic [N_POS-1:0] ONEHOT_SEAT  = 5'b10000;

    function automatic logic [2:0] count_ones(input logic [N_POS-1:0] v);
        logic [2:0] n;
        n = 3'd0;
        for (int i = 0; i < N_POS; i++) begin
            n = n + {2'b00, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: 2-FF synchroniser, counter debounce of the synchronised
// level, and a registered one-cycle pulse aligned with each accepted rise.
module debounce_channel #(
    parameter int DEBOUNCE_CYCLES = 500_000,
    parameter int CNT_W           = 19
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1;
    logic             s2;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

    // The counter only runs while s2 disagrees with the accepted level, so any
    // bounce back restarts it and it never passes CNT_LAST.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
        end else begin
            press <= 1'b0;
            if (s2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt   <= '0;
                level <= s2;
                press <= s2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/position_button_conditioner.sv
// Conditions the five bike-position buttons and tracks the last accepted
// riding position as a one-hot vector, flagging simultaneous presses.
module position_button_conditioner
    import bike_pos_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500_000,
    parameter int CNT_W           = 19
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N_POS-1:0] btn_raw,
    output logic [N_POS-1:0] btn_level,
    output logic [N_POS-1:0] btn_press,
    output logic [N_POS-1:0] position,
    output logic             position_valid,
    output logic             conflict
);

    logic [2:0] press_count;

    for (genvar i = 0; i < N_POS; i++) begin : g_chan
        debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_chan (
            .clk    (clk),
            .reset_n(reset_n),
            .raw    (btn_raw[i]),
            .level  (btn_level[i]),
            .press  (btn_press[i])
        );
    end

    assign press_count = count_ones(btn_press);

    // Several presses in one cycle are ambiguous, so position is left alone.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            position       <= '0;
            position_valid <= 1'b0;
            conflict       <= 1'b0;
        end else begin
            conflict <= 1'b0;
            if (press_count == 3'd1) begin
                position       <= btn_press;
                position_valid <= 1'b1;
            end else if (press_count > 3'd1) begin
                conflict <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_position_button_conditioner.sv
// Directed bench for position_button_conditioner with a short debounce window.
// A history-based model is compared every cycle; scenario checks pin it down.
module tb_position_button_conditioner;

    localparam int D = 8;
    localparam int W = 4;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [4:0] btn_raw;
    logic [4:0] btn_level;
    logic [4:0] btn_press;
    logic [4:0] position;
    logic       position_valid;
    logic       conflict;

    int n_cmp = 0;
    int n_bad = 0;

    position_button_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .CNT_W          (W)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .btn_raw       (btn_raw),
        .btn_level     (btn_level),
        .btn_press     (btn_press),
        .position      (position),
        .position_valid(position_valid),
        .conflict      (conflict)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Model: raw samples pass through a 2-deep history; a level flips after D
    // consecutive delayed samples disagree with it.
    logic [4:0] raw_q[$];
    int         run[5];
    logic [4:0] m_level, m_press, m_pos;
    logic       m_valid, m_conflict;

    always @(posedge clk) begin
        logic [4:0] delayed;
        if (!reset_n) begin
            raw_q.delete();
            for (int i = 0; i < 5; i++) run[i] = 0;
            m_level = '0; m_press = '0; m_pos = '0; m_valid = 1'b0; m_conflict = 1'b0;
        end else begin
            raw_q.push_back(btn_raw);
            if (raw_q.size() > 3) void'(raw_q.pop_front());
            delayed = (raw_q.size() == 3) ? raw_q[0] : 5'b0;
            m_conflict = ($countones(m_press) > 1);
            if ($countones(m_press) == 1) begin
                m_pos   = m_press;
                m_valid = 1'b1;
            end
            m_press = '0;
            for (int i = 0; i < 5; i++) begin
                run[i] = (delayed[i] != m_level[i]) ? run[i] + 1 : 0;
                if (run[i] == D) begin
                    m_level[i] = delayed[i];
                    m_press[i] = delayed[i];
                    run[i]     = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!reset_n) begin
            chk("cyc_level_rst", btn_level, 0);
            chk("cyc_press_rst", btn_press, 0);
            chk("cyc_pos_rst", position, 0);
            chk("cyc_valid_rst", position_valid, 0);
            chk("cyc_conflict_rst", conflict, 0);
        end else begin
            chk("cyc_level", btn_level, m_level);
            chk("cyc_press", btn_press, m_press);
            chk("cyc_pos", position, m_pos);
            chk("cyc_valid", position_valid, m_valid);
            chk("cyc_conflict", conflict, m_conflict);
        end
    end

    initial begin
        int cnt;
        int first;

        // 1: reset with all buttons held
        reset_n = 1'b0;
        btn_raw = 5'h1F;
        tick(3);
        chk("s1_rst_level", btn_level, 0);
        chk("s1_rst_press", btn_press, 0);
        chk("s1_rst_pos", {position_valid, position}, 0);
        chk("s1_rst_conflict", conflict, 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        tick(9);
        chk("s1_level_early", btn_level, 5'h00);
        tick(1);
        chk("s1_level_10", btn_level, 5'h1F);
        chk("s1_press_10", btn_press, 5'h1F);
        tick(1);
        chk("s1_conflict", conflict, 1);
        chk("s1_pos_hold", {position_valid, position}, 0);
        tick(1);
        chk("s1_conflict_once", conflict, 0);
        btn_raw = 5'h00;
        tick(12);
        chk("s1_release", btn_level, 5'h00);

        // 2: clean press of tops
        btn_raw[2] = 1'b1;
        tick(9);
        chk("s2_level_9", btn_level[2], 0);
        tick(1);
        chk("s2_level_10", btn_level[2], 1);
        chk("s2_press_10", btn_press, 5'b00100);
        tick(1);
        chk("s2_press_gone", btn_press, 5'b00000);
        chk("s2_pos", position, 5'b00100);
        chk("s2_valid", position_valid, 1);

        // 4: release of tops
        btn_raw[2] = 1'b0;
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            tick(1);
            if (btn_press != 0) cnt++;
        end
        chk("s4_level", btn_level[2], 0);
        chk("s4_no_press", cnt, 0);
        chk("s4_pos_kept", position, 5'b00100);

        // 3: bouncing drops button
        for (int b = 0; b < 4; b++) begin
            btn_raw[0] = (b % 2 == 0);
            tick(3);
            if (btn_press != 0) cnt++;
        end
        btn_raw[0] = 1'b1;
        cnt = 0;
        first = -1;
        for (int k = 1; k <= 14; k++) begin
            tick(1);
            if (btn_press[0]) begin
                cnt++;
                if (first < 0) first = k;
            end
        end
        chk("s3_one_pulse", cnt, 1);
        chk("s3_pulse_at_10", first, 10);
        chk("s3_pos", position, 5'b00001);
        btn_raw[0] = 1'b0;
        tick(12);

        // 5: bar then seat
        cnt = 0;
        btn_raw[3] = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick(1);
            if (conflict) cnt++;
        end
        chk("s5_pos_bar", position, 5'b01000);
        btn_raw[4] = 1'b1;
        for (int k = 0; k < 11; k++) begin
            tick(1);
            if (conflict) cnt++;
        end
        chk("s5_pos_seat", position, 5'b10000);
        chk("s5_no_conflict", cnt, 0);
        btn_raw = 5'h00;
        tick(12);

        // 6: reset in the middle of a hoods debounce
        btn_raw[1] = 1'b1;
        tick(7);
        reset_n = 1'b0;
        #1;
        chk("s6_rst_level", btn_level, 0);
        chk("s6_rst_pos", position, 0);
        chk("s6_rst_valid", position_valid, 0);
        tick(2);
        reset_n = 1'b1;
        tick(9);
        chk("s6_level_9", btn_level[1], 0);
        tick(1);
        chk("s6_press_10", btn_press, 5'b00010);
        tick(1);
        chk("s6_pos", position, 5'b00010);
        chk("s6_valid", position_valid, 1);
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
